// File: rtl/cycle_sequencer.sv
// Multi-cycle control/execute sequencer for the ARM-subset CPU.
// Walks each accepted instruction through READ -> EXEC -> (MEM) -> WB and drives
// registered regfile, data-memory, flag and branch strobes.
// Optional macro CYCLE_SEQ_MEM_EN: when defined, load/store use the MEM state;
// when undefined, memory outputs are tied to 0 and load/store retire as NOPs.
module cycle_sequencer #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned BR_SHIFT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              instr_valid,
    input  logic [31:0]       instr,
    input  logic [31:0]       pc,
    input  logic [3:0]        flags_in,
    input  logic [DATA_W-1:0] regdata1,
    input  logic [DATA_W-1:0] regdata2,
    input  logic [DATA_W-1:0] memdata,
    output logic              busy,
    output logic              done,
    output logic [3:0]        regaddrOut1,
    output logic [3:0]        regaddrOut2,
    output logic              regrd1,
    output logic              regrd2,
    output logic [3:0]        regaddrIn,
    output logic [DATA_W-1:0] regdataIn,
    output logic              regwr,
    output logic [ADDR_W-1:0] memaddr,
    output logic [DATA_W-1:0] memdataIn,
    output logic              memrd,
    output logic              memwr,
    output logic [3:0]        flags_out,
    output logic              flags_we,
    output logic              bf,
    output logic [31:0]       branchimm
);

    typedef enum logic [2:0] {StIdle, StRead, StExec, StMem, StWb} state_e;

    localparam logic [3:0] OpAnd = 4'h0, OpEor = 4'h1, OpSub = 4'h2, OpRsb = 4'h3;
    localparam logic [3:0] OpAdd = 4'h4, OpAdc = 4'h5, OpSbc = 4'h6, OpRsc = 4'h7;
    localparam logic [3:0] OpTst = 4'h8, OpTeq = 4'h9, OpCmp = 4'hA, OpCmn = 4'hB;
    localparam logic [3:0] OpOrr = 4'hC, OpMov = 4'hD, OpBic = 4'hE, OpMvn = 4'hF;

    state_e            state_q, state_d;
    logic [31:0]       instr_q, instr_d;
    logic [DATA_W-1:0] res_q, res_d, regdata_in_q, regdata_in_d;
    logic [3:0]        nzcv_q, nzcv_d, flags_out_q, flags_out_d;
    logic [3:0]        regaddr1_q, regaddr1_d, regaddr2_q, regaddr2_d, regaddr_in_q, regaddr_in_d;
    logic              busy_q, busy_d, done_q, done_d, regrd1_q, regrd1_d, regrd2_q, regrd2_d;
    logic              regwr_q, regwr_d, flags_we_q, flags_we_d, bf_q, bf_d;
    logic [31:0]       branchimm_q, branchimm_d, br_sext;

    logic [3:0]        opcode;
    logic              is_dp, is_br, is_ls, is_cmp, cond_ok, c_in, sh_c, arith, add_cin;
    logic [4:0]        amt, rot;
    logic [DATA_W-1:0] op2, imm_ext, add_a, add_b, alu_res;
    logic [DATA_W:0]   sum;
    logic [3:0]        alu_flags;
    logic              unused_instr;

    assign opcode  = instr_q[24:21];
    assign is_dp   = (instr_q[27:26] == 2'b00);
    assign is_br   = (instr_q[27:25] == 3'b101);
    assign is_ls   = (instr_q[27:26] == 2'b01);
    assign is_cmp  = (opcode[3:2] == 2'b10);
    assign c_in    = flags_in[1];
    assign amt     = instr_q[11:7];
    assign rot     = {instr_q[11:8], 1'b0};
    assign br_sext = {{8{instr_q[23]}}, instr_q[23:0]};
    // Rn comes from the live instr at accept time; bit 4 selects unsupported register shifts
    assign unused_instr = ^{instr_q[19:16], instr_q[4]};

    // Condition code check against current NZCV; 1111 never executes
    always_comb begin
        cond_ok = 1'b0;
        case (instr_q[31:28])
            4'h0: cond_ok = flags_in[2];
            4'h1: cond_ok = !flags_in[2];
            4'h2: cond_ok = flags_in[1];
            4'h3: cond_ok = !flags_in[1];
            4'h4: cond_ok = flags_in[3];
            4'h5: cond_ok = !flags_in[3];
            4'h6: cond_ok = flags_in[0];
            4'h7: cond_ok = !flags_in[0];
            4'h8: cond_ok = flags_in[1] && !flags_in[2];
            4'h9: cond_ok = !flags_in[1] || flags_in[2];
            4'hA: cond_ok = (flags_in[3] == flags_in[0]);
            4'hB: cond_ok = (flags_in[3] != flags_in[0]);
            4'hC: cond_ok = !flags_in[2] && (flags_in[3] == flags_in[0]);
            4'hD: cond_ok = flags_in[2] || (flags_in[3] != flags_in[0]);
            4'hE: cond_ok = 1'b1;
            default: cond_ok = 1'b0;
        endcase
    end

    // Operand2 barrel shifter; a zero shift amount passes Rm through with carry unchanged
    always_comb begin
        op2     = regdata2;
        sh_c    = c_in;
        imm_ext = {{(DATA_W-8){1'b0}}, instr_q[7:0]};
        if (instr_q[25]) begin
            op2  = (imm_ext >> rot) | (imm_ext << (DATA_W - rot));
            sh_c = (rot == 5'd0) ? c_in : op2[DATA_W-1];
        end else if (amt != 5'd0) begin
            case (instr_q[6:5])
                2'b00:   {sh_c, op2} = {1'b0, regdata2} << amt;
                2'b01:   {op2, sh_c} = {regdata2, 1'b0} >> amt;
                2'b10:   {op2, sh_c} = $signed({regdata2, 1'b0}) >>> amt;
                default: begin
                    op2  = (regdata2 >> amt) | (regdata2 << (DATA_W - amt));
                    sh_c = op2[DATA_W-1];
                end
            endcase
        end
    end

    // ALU: subtracts are a + ~b + cin so the carry out is the ARM not-borrow
    always_comb begin
        add_a   = regdata1;
        add_b   = op2;
        add_cin = 1'b0;
        arith   = 1'b1;
        case (opcode)
            OpSub, OpCmp: begin add_b = ~op2; add_cin = 1'b1; end
            OpRsb:        begin add_a = op2; add_b = ~regdata1; add_cin = 1'b1; end
            OpAdc:        add_cin = c_in;
            OpSbc:        begin add_b = ~op2; add_cin = c_in; end
            OpRsc:        begin add_a = op2; add_b = ~regdata1; add_cin = c_in; end
            OpAdd, OpCmn: add_cin = 1'b0;
            default:      arith = 1'b0;
        endcase
        sum = {1'b0, add_a} + {1'b0, add_b} + {{DATA_W{1'b0}}, add_cin};
        case (opcode)
            OpAnd, OpTst: alu_res = regdata1 & op2;
            OpEor, OpTeq: alu_res = regdata1 ^ op2;
            OpOrr:        alu_res = regdata1 | op2;
            OpMov:        alu_res = op2;
            OpBic:        alu_res = regdata1 & ~op2;
            OpMvn:        alu_res = ~op2;
            default:      alu_res = sum[DATA_W-1:0];
        endcase
        alu_flags[3] = alu_res[DATA_W-1];
        alu_flags[2] = (alu_res == '0);
        alu_flags[1] = arith ? sum[DATA_W] : sh_c;
        alu_flags[0] = arith ? ((add_a[DATA_W-1] == add_b[DATA_W-1]) &&
                                (alu_res[DATA_W-1] != add_a[DATA_W-1])) : flags_in[0];
    end

    // Next-state and registered-output logic; strobes default low, data outputs hold
    always_comb begin
        state_d      = state_q;
        instr_d      = instr_q;
        res_d        = res_q;
        nzcv_d       = nzcv_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        regrd1_d     = 1'b0;
        regrd2_d     = 1'b0;
        regwr_d      = 1'b0;
        flags_we_d   = 1'b0;
        bf_d         = 1'b0;
        regaddr1_d   = regaddr1_q;
        regaddr2_d   = regaddr2_q;
        regaddr_in_d = regaddr_in_q;
        regdata_in_d = regdata_in_q;
        flags_out_d  = flags_out_q;
        branchimm_d  = branchimm_q;
        case (state_q)
            StIdle: begin
                if (instr_valid) begin
                    instr_d    = instr;
                    busy_d     = 1'b1;
                    state_d    = StRead;
                    regrd1_d   = 1'b1;
                    regrd2_d   = 1'b1;
                    regaddr1_d = instr[19:16];
                    // stores read Rd on port 2 as the data to write
                    regaddr2_d = (instr[27:26] == 2'b01 && !instr[20]) ? instr[15:12] : instr[3:0];
                end
            end
            StRead: begin
                if (cond_ok) begin
                    state_d = StExec;
                end else begin
                    state_d = StIdle;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            StExec: begin
                if (is_dp) begin
                    res_d   = alu_res;
                    nzcv_d  = alu_flags;
                    state_d = StWb;
                end else if (is_br) begin
                    bf_d        = 1'b1;
                    branchimm_d = br_sext << BR_SHIFT;
                    if (instr_q[24]) begin
                        state_d = StWb;
                    end else begin
                        state_d = StIdle;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
`ifdef CYCLE_SEQ_MEM_EN
                end else if (is_ls) begin
                    state_d = StMem;
`endif
                end else begin
                    state_d = StIdle;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
`ifdef CYCLE_SEQ_MEM_EN
            StMem: begin
                if (instr_q[20]) begin
                    state_d = StWb;
                end else begin
                    state_d = StIdle;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
`endif
            StWb: begin
                state_d = StIdle;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                if (is_br) begin
                    regwr_d      = 1'b1;
                    regaddr_in_d = 4'd14;
                    regdata_in_d = pc + 32'd4;
                end else if (is_ls) begin
                    regwr_d      = 1'b1;
                    regaddr_in_d = instr_q[15:12];
                    regdata_in_d = memdata;
                end else begin
                    regwr_d      = !is_cmp;
                    regaddr_in_d = instr_q[15:12];
                    regdata_in_d = res_q;
                    flags_we_d   = instr_q[20] || is_cmp;
                    if (instr_q[20] || is_cmp) flags_out_d = nzcv_q;
                end
            end
            default: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            instr_q      <= '0;
            res_q        <= '0;
            nzcv_q       <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            regrd1_q     <= 1'b0;
            regrd2_q     <= 1'b0;
            regwr_q      <= 1'b0;
            flags_we_q   <= 1'b0;
            bf_q         <= 1'b0;
            regaddr1_q   <= '0;
            regaddr2_q   <= '0;
            regaddr_in_q <= '0;
            regdata_in_q <= '0;
            flags_out_q  <= '0;
            branchimm_q  <= '0;
        end else begin
            state_q      <= state_d;
            instr_q      <= instr_d;
            res_q        <= res_d;
            nzcv_q       <= nzcv_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            regrd1_q     <= regrd1_d;
            regrd2_q     <= regrd2_d;
            regwr_q      <= regwr_d;
            flags_we_q   <= flags_we_d;
            bf_q         <= bf_d;
            regaddr1_q   <= regaddr1_d;
            regaddr2_q   <= regaddr2_d;
            regaddr_in_q <= regaddr_in_d;
            regdata_in_q <= regdata_in_d;
            flags_out_q  <= flags_out_d;
            branchimm_q  <= branchimm_d;
        end
    end

`ifdef CYCLE_SEQ_MEM_EN
    logic [DATA_W-1:0] ls_addr, imm12;
    logic [ADDR_W-1:0] memaddr_q, memaddr_d;
    logic [DATA_W-1:0] memdata_in_q, memdata_in_d;
    logic              memrd_q, memrd_d, memwr_q, memwr_d;

    assign imm12   = {{(DATA_W-12){1'b0}}, instr_q[11:0]};
    assign ls_addr = instr_q[23] ? regdata1 + imm12 : regdata1 - imm12;

    // Memory strobes are high for exactly the MEM cycle entered from EXEC
    always_comb begin
        memrd_d      = 1'b0;
        memwr_d      = 1'b0;
        memaddr_d    = memaddr_q;
        memdata_in_d = memdata_in_q;
        if (state_q == StExec && is_ls) begin
            memaddr_d    = ls_addr[ADDR_W-1:0];
            memrd_d      = instr_q[20];
            memwr_d      = !instr_q[20];
            memdata_in_d = instr_q[20] ? memdata_in_q : regdata2;
        end
    end

    // Memory output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            memaddr_q    <= '0;
            memdata_in_q <= '0;
            memrd_q      <= 1'b0;
            memwr_q      <= 1'b0;
        end else begin
            memaddr_q    <= memaddr_d;
            memdata_in_q <= memdata_in_d;
            memrd_q      <= memrd_d;
            memwr_q      <= memwr_d;
        end
    end

    assign memaddr   = memaddr_q;
    assign memdataIn = memdata_in_q;
    assign memrd     = memrd_q;
    assign memwr     = memwr_q;
`else
    assign memaddr   = '0;
    assign memdataIn = '0;
    assign memrd     = 1'b0;
    assign memwr     = 1'b0;
`endif

    assign busy        = busy_q;
    assign done        = done_q;
    assign regaddrOut1 = regaddr1_q;
    assign regaddrOut2 = regaddr2_q;
    assign regrd1      = regrd1_q;
    assign regrd2      = regrd2_q;
    assign regaddrIn   = regaddr_in_q;
    assign regdataIn   = regdata_in_q;
    assign regwr       = regwr_q;
    assign flags_out   = flags_out_q;
    assign flags_we    = flags_we_q;
    assign bf          = bf_q;
    assign branchimm   = branchimm_q;

endmodule

// File: doc/cycle_sequencer.md
Name: cycle_sequencer

Overview:
- Parametrised multi-cycle control and execute sequencer for the ARM-subset CPU.
- Owns its own state machine instead of taking an external state count.
- Accepts one instruction word at a time, evaluates its condition code, then runs the operation through four phases: read regfile, execute, optional memory, writeback.
- Drives register-file, data-memory, flag and branch strobes. Sits between the fetch unit and the regfile/memory.

Parameters:
DATA_W, 32, datapath width; must be 32 for ARM operand2 encoding.
ADDR_W, 32, data-memory address width; memory address = low ADDR_W bits of the computed address.
BR_SHIFT, 2, left shift applied to the sign-extended 24-bit branch offset.

Ports:
clk  in  1  clock, all state on posedge
reset  in  1  synchronous, active-high
instr_valid  in  1  instruction offered; accepted only when busy=0
instr  in  32  instruction word
pc  in  32  address of the instruction; stable while busy
flags_in  in  4  current NZCV
regdata1  in  DATA_W  regfile port 1 data, valid the cycle after regrd1
regdata2  in  DATA_W  regfile port 2 data, valid the cycle after regrd2
memdata  in  DATA_W  memory read data, valid the cycle after memrd
busy  out  1  high from the accept cycle until done
done  out  1  one-cycle pulse at instruction retirement
regaddrOut1  out  4  read address for port 1 (Rn)
regaddrOut2  out  4  read address for port 2 (Rm, or Rd for a store)
regrd1  out  1  read strobe, port 1
regrd2  out  1  read strobe, port 2
regaddrIn  out  4  write address
regdataIn  out  DATA_W  write data
regwr  out  1  write strobe
memaddr  out  ADDR_W  memory address
memdataIn  out  DATA_W  store data
memrd  out  1  memory read strobe
memwr  out  1  memory write strobe
flags_out  out  4  new NZCV
flags_we  out  1  flag write strobe
bf  out  1  branch-taken pulse
branchimm  out  32  branch displacement

Behaviour:
- Reset: state=IDLE. All outputs are registered and 0 on reset, including busy, done, all strobes, addresses and data.
- Reset mid-instruction: return to IDLE on the next edge. No regwr, memwr, flags_we or bf is issued afterwards, and no done pulse.
- States: IDLE, READ, EXEC, MEM, WB.
- IDLE: when instr_valid=1, latch instr, set busy=1, go to READ.
- READ:
  - Assert regrd1 (addr=instr[19:16]) and regrd2 (addr=instr[3:0], or instr[15:12] for a store).
  - Evaluate cond instr[31:28] against flags_in using all 15 ARM codes; 1111 counts as never.
  - Condition fails: go to IDLE, pulse done, busy=0, no side effects.
- EXEC:
  - Data-processing (instr[27:26]=00), all 16 opcodes AND..MVN:
    - Operand2 with I=1: imm8 rotated right by 2*rot4.
    - Operand2 with I=0: Rm shifted LSL/LSR/ASR/ROR by imm5.
  - Register the result, then go to WB.
  - Branch (instr[27:25]=101):
    - Pulse bf=1 for one cycle.
    - branchimm = sign-extended offset24 << BR_SHIFT.
    - BL goes to WB; B goes to IDLE and pulses done.
  - Load/store (27:26=01): compute address = Rn ± imm12 (U bit), go to MEM.
- MEM: assert memrd, or assert memwr with memdataIn=Rd, for one cycle. Load goes to WB; store goes to IDLE and pulses done.
- WB:
  - regwr=1, with regaddrIn=Rd, or 14 for BL with data pc+4.
  - TST/TEQ/CMP/CMN never assert regwr.
  - flags_we=1 when S=1 or for a compare op.
  - Pulse done; go to IDLE.
- Flags:
  - N = result[31]; Z = (result==0).
  - Arithmetic ops: C = carry-out (not-borrow for subtracts); V = signed overflow.
  - Logical ops: C = shifter carry-out (unchanged if shift amount 0); V unchanged.
  - ADC/SBC/RSC use flags_in C.
- Latency from the accept edge: data op 3 cycles to done, load 4, store 3, B 2, BL 3, failed condition 1.
- instr_valid while busy=1 is ignored and does not stall or corrupt the current instruction.
- A new instruction may be accepted in the cycle after done.

Optional Feature:
CYCLE_SEQ_MEM_EN
- Defined: load/store support as described above.
- Undefined: the MEM state and memory strobes are compiled out. memrd, memwr, memaddr and memdataIn are tied to 0. Load/store encodings retire as NOPs: done 1 cycle after READ, no writes.

Test Plan:
- Reset, then ADD r1=r2+imm 5 with r2=7, cond AL, S=1 -> regwr with regaddrIn=1, regdataIn=12 exactly 3 cycles after accept; flags_out=0000; done one cycle.
- SUBS r3=r4-r4 (r4=9) -> regdataIn=0, flags_out N0 Z1 C1 V0, flags_we=1; CMP r4,#9 -> flags_we=1, regwr never high.
- BEQ offset 0xFFFFFE with Z=1 -> bf pulse, branchimm=0xFFFFFFF8, done 2 cycles after accept; same instruction with Z=0 -> no bf, done after 1 cycle.
- BL offset 3, pc=0x100 -> branchimm=0x0C, then regwr to r14 with data 0x104.
- LDR r5,[r6,#8] with r6=0x20, memdata=0xDEADBEEF (macro on) -> memrd with memaddr=0x28, then r5=0xDEADBEEF; macro off -> no memrd, done 1 cycle after READ.
- Assert reset during EXEC of ADD -> no regwr, no done, busy=0 next cycle; instr_valid held high during busy is ignored.
